branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the next-generation 5-stage RV32 pipeline.
- Sits beside the PC and its adder. IF looks it up combinationally with the fetch PC; ID sends back resolved branch and jump outcomes.
- Holds a direct-mapped, tagged branch target buffer (BTB) and a table of saturating counters.
- Supports bimodal mode or gshare mode (global history XOR PC), and counts mispredicts for performance monitoring.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB and counter-table depth; power of 2, at least 4.
- TAG_WIDTH, 8, BTB tag bits taken above the index.
- CTR_WIDTH, 2, saturating counter width, 1..4.
- GHR_WIDTH, 0, global history length; 0 selects bimodal, otherwise gshare with GHR_WIDTH ≤ log2(ENTRIES).
- CNT_WIDTH, 16, mispredict counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- lookupPc  in  XLEN  fetch PC from IF
- predTaken  out  1  predict redirect
- predTarget  out  XLEN  predicted next PC
- btbHit  out  1  tag match on a valid entry
- updValid  in  1  resolved control-flow instruction this cycle
- updPc  in  XLEN  PC of the resolved instruction
- updIsJump  in  1  1 = JAL/JALR, 0 = conditional branch
- updTaken  in  1  actual outcome
- updTarget  in  XLEN  actual target
- updPredTaken  in  1  prediction originally made, carried down the pipeline
- updPredTarget  in  XLEN  target originally predicted
- mispredict  out  1  registered mispredict flag
- mispredictCount  out  CNT_WIDTH  saturating mispredict total

Behaviour:
- Field definitions:
  - IDX = log2(ENTRIES).
  - Index = pc[IDX+1:2].
  - Tag = pc[IDX+TAG_WIDTH+1:IDX+2].
  - Counter index = Index in bimodal mode; {Index} XOR zero-extended GHR in gshare mode.
- Lookup (combinational, zero latency):
  - btbHit = valid[Index] && tag[Index] == lookup tag.
  - predTaken = btbHit && (isJump[Index] || ctr[ctrIdx] MSB).
  - predTarget = predTaken ? target[Index] : lookupPc + 4. The add wraps modulo 2^XLEN.
- Update (takes effect at the clock edge when updValid = 1):
  - Counter moves +1 if taken, -1 if not taken, saturating at 0 and 2^CTR_WIDTH-1. Only conditional branches update counters; jumps never do.
  - BTB entry is written (valid = 1, tag, target, isJump) only when updTaken = 1. A not-taken outcome leaves the BTB unchanged.
  - In gshare mode, GHR shifts left by one with updTaken as the LSB, for conditional branches only. The counter is indexed with the pre-shift GHR.
- Same-cycle lookup and update to the same index:
  - Lookup returns the pre-update contents (read-old).
  - The new contents are visible from the next cycle.
- Mispredict detection:
  - Condition: updValid && (updTaken != updPredTaken || (updTaken && updTarget != updPredTarget)).
  - mispredict is registered: high exactly one cycle after that updValid cycle, low otherwise.
  - mispredictCount increments on the same edge, saturates at all-ones and never wraps.
- Reset (synchronous, active-high, one cycle):
  - All valid bits = 0.
  - Counters = weakly not-taken (2^(CTR_WIDTH-1) - 1; value 0 when CTR_WIDTH = 1).
  - GHR = 0, mispredict = 0, mispredictCount = 0.
  - Tag/target arrays need no reset.
  - rst dominates updValid in the same cycle; that update is discarded.
  - Outputs during and after reset follow the lookup rules: predTaken = 0, predTarget = lookupPc + 4.
- Aliasing: index conflicts overwrite silently, with no replacement policy. A tag mismatch means no prediction.

Decomposition:
- Shared package definitions:
  - predictor counter typedef (ctr_t sized by CTR_WIDTH via a parameterised width constant);
  - weakly-not-taken reset constant;
  - PC_STEP = 4.
- Sub-module sat_counter:
  - parametrised by width;
  - inputs: inc, dec, current value;
  - output: next value, saturating.
  - Used per update path and reused for mispredictCount.

Test Plan:
1. Reset, then lookupPc = 0x100 → btbHit = 0, predTaken = 0, predTarget = 0x104, mispredictCount = 0.
2. Conditional branch at updPc = 0x100, taken to 0x80, predicted not-taken:
   - after first update: mispredict pulses one cycle later and count = 1; lookup 0x100 gives btbHit = 1, predTaken = 1, predTarget = 0x80 (counter 01→10).
   - repeat taken, predicted taken/0x80: counter goes to 11, no mispredict, count stays 1.
3. Four not-taken updates at 0x100 → counter saturates at 00 and predTaken = 0 while btbHit = 1. One further taken update → counter 01, still predicts not-taken.
4. JAL at 0x200 to 0x400, taken → lookup 0x200 predicts taken to 0x400. Counter at its index is unchanged; GHR is unchanged in gshare mode.
5. Alias: with ENTRIES = 64, update 0x100 and then 0x1100 (same index, different tag) → lookup 0x100 gives btbHit = 0; lookup 0x1100 hits.
6. Edge cases:
   - same-cycle lookup and update of 0x300 → lookup shows the old miss; the next cycle shows the hit.
   - rst asserted together with updValid → no entry written.
   - CNT_WIDTH = 2 with 5 mispredicts → count holds at 3.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: counter type,
// weakly-not-taken reset value and the sequential PC step.
package branch_predictor_pkg;

  localparam int unsigned PC_STEP = 4;
  localparam int unsigned CTR_W   = 2;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_WEAK_NT = ctr_t'((1 << (CTR_W - 1)) - 1);

  // Weakly-not-taken value for any counter width 1..4 (0 for a 1-bit counter).
  function automatic logic [3:0] weakNotTaken(input int unsigned w);
    return 4'((1 << (w - 1)) - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter step: produces the next value of a W-bit
// counter, holding at 0 and at all-ones.
module sat_counter #(
  parameter int W = 2
) (
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (inc && !dec && (cur != {W{1'b1}})) begin
      nxt = cur + W'(1);
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped tagged BTB plus a table of
// saturating counters, bimodal or gshare indexed, with mispredict counting.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int TAG_WIDTH = 8,
  parameter int CTR_WIDTH = 2,
  parameter int GHR_WIDTH = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      lookupPc,
  output logic                 predTaken,
  output logic [XLEN-1:0]      predTarget,
  output logic                 btbHit,
  input  logic                 updValid,
  input  logic [XLEN-1:0]      updPc,
  input  logic                 updIsJump,
  input  logic                 updTaken,
  input  logic [XLEN-1:0]      updTarget,
  input  logic                 updPredTaken,
  input  logic [XLEN-1:0]      updPredTarget,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] mispredictCount
);

  localparam int IDX = $clog2(ENTRIES);

  logic                 validQ  [ENTRIES];
  logic                 isJumpQ [ENTRIES];
  logic [TAG_WIDTH-1:0] tagQ    [ENTRIES];
  logic [XLEN-1:0]      targetQ [ENTRIES];
  logic [CTR_WIDTH-1:0] ctrQ    [ENTRIES];

  logic [IDX-1:0]       lkIdx;
  logic [IDX-1:0]       lkCtrIdx;
  logic [TAG_WIDTH-1:0] lkTag;
  logic [IDX-1:0]       upIdx;
  logic [IDX-1:0]       upCtrIdx;
  logic [TAG_WIDTH-1:0] upTag;
  logic [IDX-1:0]       ghrIdx;

  logic                 ctrWrite;
  logic                 btbWrite;
  logic [CTR_WIDTH-1:0] ctrCur;
  logic [CTR_WIDTH-1:0] ctrNext;
  logic                 misCond;
  logic [CNT_WIDTH-1:0] cntNext;
  logic                 unusedUpdPcBits;

  assign lkIdx    = lookupPc[IDX+1:2];
  assign lkTag    = lookupPc[IDX+TAG_WIDTH+1:IDX+2];
  assign lkCtrIdx = lkIdx ^ ghrIdx;

  assign upIdx    = updPc[IDX+1:2];
  assign upTag    = updPc[IDX+TAG_WIDTH+1:IDX+2];
  assign upCtrIdx = upIdx ^ ghrIdx;

  assign unusedUpdPcBits = ^{updPc[1:0], updPc[XLEN-1:IDX+TAG_WIDTH+2]};

  // Lookup reads the arrays as they stand this cycle, so a same-cycle
  // update to the same entry is only visible from the next cycle.
  assign btbHit     = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
  assign predTaken  = btbHit && (isJumpQ[lkIdx] || ctrQ[lkCtrIdx][CTR_WIDTH-1]);
  assign predTarget = predTaken ? targetQ[lkIdx] : lookupPc + XLEN'(PC_STEP);

  assign ctrWrite = updValid && !updIsJump;
  assign btbWrite = updValid && updTaken;
  assign ctrCur   = ctrQ[upCtrIdx];

  sat_counter #(.W(CTR_WIDTH)) uCtrSat (
    .inc (updTaken),
    .dec (!updTaken),
    .cur (ctrCur),
    .nxt (ctrNext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
        ctrQ[i]   <= CTR_WIDTH'(weakNotTaken(CTR_WIDTH));
      end
    end else begin
      if (btbWrite) validQ[upIdx] <= 1'b1;
      if (ctrWrite) ctrQ[upCtrIdx] <= ctrNext;
    end
  end

  // Payload arrays are qualified by validQ, so they carry no reset.
  always_ff @(posedge clk) begin
    if (btbWrite && !rst) begin
      tagQ[upIdx]    <= upTag;
      targetQ[upIdx] <= updTarget;
      isJumpQ[upIdx] <= updIsJump;
    end
  end

  generate
    if (GHR_WIDTH > 0) begin : genGshare
      logic [GHR_WIDTH-1:0] ghrQ;

      always_ff @(posedge clk) begin
        if (rst) begin
          ghrQ <= '0;
        end else if (ctrWrite) begin
          ghrQ <= (ghrQ << 1) | GHR_WIDTH'(updTaken);
        end
      end

      assign ghrIdx = IDX'(ghrQ);
    end else begin : genBimodal
      assign ghrIdx = '0;
    end
  endgenerate

  assign misCond = updValid &&
                   ((updTaken != updPredTaken) ||
                    (updTaken && (updTarget != updPredTarget)));

  sat_counter #(.W(CNT_WIDTH)) uCntSat (
    .inc (misCond),
    .dec (1'b0),
    .cur (mispredictCount),
    .nxt (cntNext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict      <= 1'b0;
      mispredictCount <= '0;
    end else begin
      mispredict      <= misCond;
      mispredictCount <= cntNext;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance share one
// stimulus stream and are compared against an array-based reference model.
module tb_branch_predictor;

  localparam int ENT  = 64;
  localparam int IDXB = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookupPc;
  logic        updValid;
  logic [31:0] updPc;
  logic        updIsJump;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updPredTaken;
  logic [31:0] updPredTarget;

  logic        hitW   [2];
  logic        takenW [2];
  logic [31:0] tgtW   [2];
  logic        misW   [2];
  logic [3:0]  cntB;
  logic [1:0]  cntG;

  always #5 clk = ~clk;

  branch_predictor #(.CTR_WIDTH(2), .GHR_WIDTH(0), .CNT_WIDTH(4)) dutB (
    .clk(clk), .rst(rst), .lookupPc(lookupPc),
    .predTaken(takenW[0]), .predTarget(tgtW[0]), .btbHit(hitW[0]),
    .updValid(updValid), .updPc(updPc), .updIsJump(updIsJump),
    .updTaken(updTaken), .updTarget(updTarget),
    .updPredTaken(updPredTaken), .updPredTarget(updPredTarget),
    .mispredict(misW[0]), .mispredictCount(cntB)
  );

  branch_predictor #(.CTR_WIDTH(3), .GHR_WIDTH(4), .CNT_WIDTH(2)) dutG (
    .clk(clk), .rst(rst), .lookupPc(lookupPc),
    .predTaken(takenW[1]), .predTarget(tgtW[1]), .btbHit(hitW[1]),
    .updValid(updValid), .updPc(updPc), .updIsJump(updIsJump),
    .updTaken(updTaken), .updTarget(updTarget),
    .updPredTaken(updPredTaken), .updPredTarget(updPredTarget),
    .mispredict(misW[1]), .mispredictCount(cntG)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state, one set per instance.
  int          mValid  [2][ENT];
  int          mJump   [2][ENT];
  int          mTag    [2][ENT];
  logic [31:0] mTarget [2][ENT];
  int          mCtr    [2][ENT];
  int          mGhr    [2];
  int          mMis    [2];
  int          mCnt    [2];
  bit          known = 1'b0;

  function automatic int ctrW(input int d);    return (d == 0) ? 2 : 3;  endfunction
  function automatic int ctrMax(input int d);  return (1 << ctrW(d)) - 1; endfunction
  function automatic int ctrWeak(input int d); return (1 << (ctrW(d) - 1)) - 1; endfunction
  function automatic int cntMax(input int d);  return (d == 0) ? 15 : 3; endfunction
  function automatic int ghrMask(input int d); return (d == 0) ? 0 : 15; endfunction

  function automatic int pcIdx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int pcTag(input logic [31:0] pc);
    return int'((pc >> (IDXB + 2)) % 256);
  endfunction

  function automatic int ctrIdx(input int d, input logic [31:0] pc);
    return pcIdx(pc) ^ mGhr[d];
  endfunction

  function automatic void predict(input int d, input logic [31:0] pc,
                                  output bit hit, output bit tk, output logic [31:0] tgt);
    int i;
    i   = pcIdx(pc);
    hit = (mValid[d][i] == 1) && (mTag[d][i] == pcTag(pc));
    tk  = hit && ((mJump[d][i] == 1) || (mCtr[d][ctrIdx(d, pc)] > ctrWeak(d)));
    tgt = tk ? mTarget[d][i] : pc + 32'd4;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ENT; i++) begin
        mValid[d][i] = 0;
        mCtr[d][i]   = ctrWeak(d);
      end
      mGhr[d] = 0;
      mMis[d] = 0;
      mCnt[d] = 0;
    end
  endtask

  task automatic modelUpdate(input int d);
    int  ci;
    int  i;
    bit  mis;
    mis = 1'b0;
    if (updValid) begin
      ci = ctrIdx(d, updPc);
      i  = pcIdx(updPc);
      if (!updIsJump) begin
        if (updTaken) mCtr[d][ci] = (mCtr[d][ci] < ctrMax(d)) ? mCtr[d][ci] + 1 : ctrMax(d);
        else          mCtr[d][ci] = (mCtr[d][ci] > 0) ? mCtr[d][ci] - 1 : 0;
        mGhr[d] = ((mGhr[d] << 1) | int'(updTaken)) & ghrMask(d);
      end
      if (updTaken) begin
        mValid[d][i]  = 1;
        mTag[d][i]    = pcTag(updPc);
        mTarget[d][i] = updTarget;
        mJump[d][i]   = int'(updIsJump);
      end
      mis = (updTaken != updPredTaken) || (updTaken && (updTarget != updPredTarget));
    end
    mMis[d] = int'(mis);
    if (mis && (mCnt[d] < cntMax(d))) mCnt[d]++;
  endtask

  task automatic step(input bit r, input bit uv, input logic [31:0] upc, input bit isJ,
                      input bit tk, input logic [31:0] tgt, input bit pt,
                      input logic [31:0] ptgt, input logic [31:0] lpc);
    bit          eh;
    bit          et;
    logic [31:0] eg;
    @(negedge clk);
    rst           = r;
    updValid      = uv;
    updPc         = upc;
    updIsJump     = isJ;
    updTaken      = tk;
    updTarget     = tgt;
    updPredTaken  = pt;
    updPredTarget = ptgt;
    lookupPc      = lpc;
    #1;
    if (known) begin
      for (int d = 0; d < 2; d++) begin
        predict(d, lpc, eh, et, eg);
        check($sformatf("btbHit[%0d]@%h", d, lpc), 32'(hitW[d]), 32'(eh));
        check($sformatf("predTaken[%0d]@%h", d, lpc), 32'(takenW[d]), 32'(et));
        check($sformatf("predTarget[%0d]@%h", d, lpc), tgtW[d], eg);
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      modelReset();
      known = 1'b1;
    end else if (known) begin
      for (int d = 0; d < 2; d++) modelUpdate(d);
    end
    if (known) begin
      check("mispredict[0]", 32'(misW[0]), 32'(mMis[0]));
      check("mispredict[1]", 32'(misW[1]), 32'(mMis[1]));
      check("count[0]", 32'(cntB), 32'(mCnt[0]));
      check("count[1]", 32'(cntG), 32'(mCnt[1]));
    end
  endtask

  function automatic logic [31:0] rndPc();
    return 32'h1000 | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    bit          ph;
    bit          pt;
    logic [31:0] pg;
    logic [31:0] upc;
    logic [31:0] lpc;
    logic [31:0] tgt;
    bit          isJ;
    bit          tk;

    rst = 1'b1; updValid = 1'b0; updPc = '0; updIsJump = 1'b0; updTaken = 1'b0;
    updTarget = '0; updPredTaken = 1'b0; updPredTarget = '0; lookupPc = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    check("reset_hit", 32'(hitW[0]), 32'd0);
    check("reset_target", tgtW[0], 32'h104);
    check("reset_count", 32'(cntB), 32'd0);

    step(0, 1, 32'h100, 0, 1, 32'h80, 0, 32'h0, 32'h100);
    check("first_taken_hit", 32'(hitW[0]), 32'd1);
    check("first_taken_target", tgtW[0], 32'h80);
    check("first_taken_count", 32'(cntB), 32'd1);
    step(0, 1, 32'h100, 0, 1, 32'h80, 1, 32'h80, 32'h100);
    check("correct_pred_count", 32'(cntB), 32'd1);

    for (int k = 0; k < 4; k++) step(0, 1, 32'h100, 0, 0, 32'h0, 1, 32'h80, 32'h100);
    check("sat_low_hit", 32'(hitW[0]), 32'd1);
    check("sat_low_taken", 32'(takenW[0]), 32'd0);
    step(0, 1, 32'h100, 0, 1, 32'h80, 0, 32'h0, 32'h100);
    check("weak_nt_taken", 32'(takenW[0]), 32'd0);

    step(0, 1, 32'h200, 1, 1, 32'h400, 0, 32'h0, 32'h200);
    check("jal_taken", 32'(takenW[0]), 32'd1);
    check("jal_target", tgtW[0], 32'h400);

    step(0, 1, 32'h1100, 0, 1, 32'h900, 0, 32'h0, 32'h100);
    check("alias_old_miss", 32'(hitW[0]), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h1100);
    check("alias_new_hit", 32'(hitW[0]), 32'd1);

    step(0, 1, 32'h300, 0, 1, 32'h600, 0, 32'h0, 32'h300);
    check("same_cycle_next_hit", 32'(hitW[0]), 32'd1);

    step(1, 1, 32'h500, 1, 1, 32'ha00, 0, 32'h0, 32'h500);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h500);
    check("rst_upd_hit0", 32'(hitW[0]), 32'd0);
    check("rst_upd_hit1", 32'(hitW[1]), 32'd0);

    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hffff_fffc);
    check("wrap_target", tgtW[0], 32'h0);

    for (int k = 0; k < 20; k++) step(0, 1, 32'h700, 1, 1, 32'h40, 0, 32'h0, 32'h700);
    check("count_sat_b", 32'(cntB), 32'd15);
    check("count_sat_g", 32'(cntG), 32'd3);

    for (int n = 0; n < 600; n++) begin
      upc = rndPc();
      lpc = ($urandom_range(0, 19) == 0) ? 32'hffff_fffc : rndPc();
      isJ = ($urandom_range(0, 3) == 0);
      tk  = isJ ? 1'b1 : 1'($urandom_range(0, 1));
      tgt = 32'h2000 | (32'($urandom_range(0, 15)) << 4);
      predict(0, upc, ph, pt, pg);
      if ($urandom_range(0, 9) < 3) begin
        pt = 1'($urandom_range(0, 1));
        pg = 32'h2000 | (32'($urandom_range(0, 15)) << 4);
      end
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), upc, isJ, tk, tgt,
           pt, pg, lpc);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
